// File: rtl/lock_seq_ctrl.sv
// Keypad lock sequencer: digit entry over valid/ready, code compare, open/re-program/lockout
// control, and scheduling of the shared 2:1 LED display mux (select plus both source nibbles).
module lock_seq_ctrl #(
  parameter int                NDIG      = 4,
  parameter int                MAX_TRY   = 3,
  parameter int                LOCK_CYC  = 16,
  parameter int                BLINK_CYC = 4,
  parameter logic [4*NDIG-1:0] DEF_CODE  = 16'h1234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic       key_ready,
  input  logic       key_clear,
  input  logic       key_prog,
  output logic       sel,
  output logic [3:0] disp_a,
  output logic [3:0] disp_b,
  output logic       unlocked,
  output logic       alarm,
  output logic [3:0] fail_cnt
);

  localparam int CODE_W = 4 * NDIG;
  localparam int CNT_W  = $clog2(NDIG + 1);
  localparam int LCK_W  = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam int BLK_W  = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);
  localparam logic [LCK_W-1:0] LCK_LOAD = LCK_W'(LOCK_CYC - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYC - 1);
  localparam logic [3:0]       TRY_MAX  = 4'(MAX_TRY);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_SETCODE = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LCK_W-1:0]  lock_q, lock_d;
  logic [BLK_W-1:0]  blink_q, blink_d;
  logic              sel_q, sel_d;
  logic [3:0]        disp_a_q, disp_a_d;
  logic [3:0]        disp_b_q, disp_b_d;
  logic              unlocked_q, unlocked_d;
  logic              alarm_q, alarm_d;
  logic [3:0]        fail_q, fail_d;
  logic              ready_q, ready_d;

  logic              digit_ok_s;
  logic [CODE_W-1:0] buf_shift_s;
  logic              blink_wrap_s;

  // A clear in the same cycle drops the digit; non-BCD digits are consumed but never stored.
  assign digit_ok_s   = key_valid & ready_q & ~key_clear & (key_digit < 4'd10);
  assign buf_shift_s  = (buf_q << 4) | CODE_W'(key_digit);
  assign blink_wrap_s = (blink_q == BLK_LAST);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    lock_d   = lock_q;
    disp_a_d = disp_a_q;
    fail_d   = fail_q;

    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (key_clear) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (digit_ok_s) begin
          buf_d    = buf_shift_s;
          cnt_d    = cnt_q + CNT_W'(1);
          disp_a_d = key_digit;
          state_d  = (cnt_q == LAST_DIG) ? S_CHECK : S_ENTRY;
        end else begin
          state_d = state_q;
        end
      end
      S_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (buf_q == code_q) begin
          fail_d  = 4'd0;
          state_d = S_OPEN;
        end else if ((fail_q + 4'd1) >= TRY_MAX) begin
          fail_d  = TRY_MAX;
          lock_d  = LCK_LOAD;
          state_d = S_LOCKOUT;
        end else begin
          fail_d  = fail_q + 4'd1;
          state_d = S_IDLE;
        end
      end
      S_OPEN: begin
        if (key_clear) begin
          state_d = S_IDLE;
        end else if (key_prog) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_SETCODE;
        end else begin
          state_d = S_OPEN;
        end
      end
      S_SETCODE: begin
        if (key_clear) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_OPEN;
        end else if (digit_ok_s) begin
          disp_a_d = key_digit;
          if (cnt_q == LAST_DIG) begin
            code_d  = buf_shift_s;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_OPEN;
          end else begin
            buf_d = buf_shift_s;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = S_SETCODE;
        end
      end
      S_LOCKOUT: begin
        if (lock_q == '0) begin
          fail_d  = 4'd0;
          state_d = S_IDLE;
        end else begin
          lock_d = lock_q - LCK_W'(1);
        end
      end
      default: begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_IDLE:    disp_b_d = 4'h0;
      S_ENTRY:   disp_b_d = 4'(cnt_d);
      S_OPEN:    disp_b_d = 4'hA;
      S_SETCODE: disp_b_d = 4'h5;
      S_LOCKOUT: disp_b_d = 4'hE;
      default:   disp_b_d = disp_b_q;
    endcase

    unlocked_d = (state_d == S_OPEN) || (state_d == S_SETCODE);
    alarm_d    = (state_d == S_LOCKOUT);
    ready_d    = (state_d != S_CHECK) && (state_d != S_LOCKOUT);

    blink_d = blink_wrap_s ? '0 : (blink_q + BLK_W'(1));
    if (state_d == S_LOCKOUT) begin
      sel_d = 1'b1;
    end else if (blink_wrap_s) begin
      sel_d = ~sel_q;
    end else begin
      sel_d = sel_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      code_q     <= DEF_CODE;
      buf_q      <= '0;
      cnt_q      <= '0;
      lock_q     <= '0;
      blink_q    <= '0;
      sel_q      <= 1'b0;
      disp_a_q   <= 4'h0;
      disp_b_q   <= 4'h0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      fail_q     <= 4'd0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      blink_q    <= blink_d;
      sel_q      <= sel_d;
      disp_a_q   <= disp_a_d;
      disp_b_q   <= disp_b_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
      fail_q     <= fail_d;
      ready_q    <= ready_d;
    end
  end

  assign key_ready = ready_q;
  assign sel       = sel_q;
  assign disp_a    = disp_a_q;
  assign disp_b    = disp_b_q;
  assign unlocked  = unlocked_q;
  assign alarm     = alarm_q;
  assign fail_cnt  = fail_q;

endmodule
